// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 4x4 output-stationary systolic array.
// Holds the A and B operand matrices, clears the array, then streams skewed
// rows of A into column 0 and skewed columns of B into row 0 over ten cycles,
// waits one drain cycle and pulses done. All outputs come straight from flops.
module systolic_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [1:0]  wr_row,
  input  logic [31:0] wr_data,
  input  logic        start,
  output logic [31:0] a_feed,
  output logic [31:0] b_feed,
  output logic        array_rst,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_FEED = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_buf_q [4];
  logic [31:0] a_buf_d [4];
  logic [31:0] b_buf_q [4];
  logic [31:0] b_buf_d [4];
  logic [31:0] a_feed_q, a_feed_d;
  logic [31:0] b_feed_q, b_feed_d;
  logic        array_rst_q, array_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and feed-cycle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == LAST_FEED) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand buffer writes, accepted only while idle.
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (state_q == S_IDLE && wr_en) begin
      if (wr_sel) b_buf_d[wr_row] = wr_data;
      else        a_buf_d[wr_row] = wr_data;
    end
  end

  // Registered outputs are computed from the next state so that they line up
  // with the state they describe; feed byte i carries element k when t = i + k.
  always_comb begin
    a_feed_d    = '0;
    b_feed_d    = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    array_rst_d = (state_d == S_CLEAR);
    if (state_d == S_FEED) begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (cnt_d == 4'(i + k)) begin
            a_feed_d[8*i +: 8] = a_buf_q[i][8*k +: 8];
            b_feed_d[8*i +: 8] = b_buf_q[k][8*i +: 8];
          end
        end
      end
    end
  end

  // State, buffers and output flops; reset also holds the array in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        a_buf_q[i] <= '0;
        b_buf_q[i] <= '0;
      end
      a_feed_q    <= '0;
      b_feed_q    <= '0;
      array_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      for (int unsigned i = 0; i < 4; i++) begin
        a_buf_q[i] <= a_buf_d[i];
        b_buf_q[i] <= b_buf_d[i];
      end
      a_feed_q    <= a_feed_d;
      b_feed_q    <= b_feed_d;
      array_rst_q <= array_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign a_feed    = a_feed_q;
  assign b_feed    = b_feed_q;
  assign array_rst = array_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed bench for systolic_ctrl with a behavioural
// 4x4 output-stationary PE array driven by the controller's feeds.
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_sel, start;
  logic [1:0]  wr_row;
  logic [31:0] wr_data;
  logic [31:0] a_feed, b_feed;
  logic        array_rst, busy, done;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] exp_a [10];
  logic [31:0] exp_b [10];
  int          exp_c [4][4];
  logic [31:0] d;
  logic        seen;

  logic signed [7:0]  pa [4][4];
  logic signed [7:0]  pb [4][4];
  logic signed [31:0] pc [4][4];
  logic signed [7:0]  ai, bi;

  systolic_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .start     (start),
    .a_feed    (a_feed),
    .b_feed    (b_feed),
    .array_rst (array_rst),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural PE array: a flows right, b flows down, c accumulates a*b.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0) ai = a_feed[8*i +: 8];
        else        ai = pa[i][j-1];
        if (i == 0) bi = b_feed[8*j +: 8];
        else        bi = pb[i-1][j];
        if (array_rst) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= '0;
        end else begin
          pa[i][j] <= ai;
          pb[i][j] <= bi;
          pc[i][j] <= pc[i][j] + ai * bi;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes one buffer row; with go set, start rides along and do_run consumes the edge.
  task automatic wr(input logic sel, input logic [1:0] row, input logic [31:0] data, input logic go);
    wr_en = 1'b1; wr_sel = sel; wr_row = row; wr_data = data; start = go;
    if (!go) begin
      tick();
      wr_en = 1'b0;
    end
  endtask

  // Caller has start (and maybe a write) pending; this walks cycles 1..14.
  task automatic do_run(input bit trace, input bit poke, input bit dstart);
    tick(); start = 1'b0; wr_en = 1'b0;
    chk("clear_array_rst", {31'd0, array_rst}, 32'd1);
    chk("clear_busy", {31'd0, busy}, 32'd1);
    chk("clear_feeds", a_feed | b_feed, 32'd0);
    for (int t = 0; t < 10; t++) begin
      tick(); start = 1'b0; wr_en = 1'b0;
      if (t == 0) chk("feed_array_rst", {31'd0, array_rst}, 32'd0);
      if (trace) begin
        chk($sformatf("a_feed_t%0d", t), a_feed, exp_a[t]);
        chk($sformatf("b_feed_t%0d", t), b_feed, exp_b[t]);
      end
      if (poke && t == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd3; wr_data = 32'h7F7F7F7F;
      end
    end
    tick(); start = 1'b0; wr_en = 1'b0;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_done", {31'd0, done}, 32'd0);
    chk("drain_feeds", a_feed | b_feed, 32'd0);
    if (dstart) start = 1'b1;
    tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd1);
    tick(); start = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("pe_c%0d%0d", i, j), pc[i][j], exp_c[i][j]);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_a_feed", a_feed, 32'd0);
    chk("rst_b_feed", b_feed, 32'd0);
    chk("rst_array_rst", {31'd0, array_rst}, 32'd1);
    rst = 1'b0;
    tick();
    chk("post_rst_array_rst", {31'd0, array_rst}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Run 1: A = identity, B = 1..16; last write shares the cycle with start.
    for (int r = 0; r < 4; r++) wr(1'b0, 2'(r), 32'h1 << (8*r), 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) d[8*c +: 8] = 8'(4*r + c + 1);
      wr(1'b1, 2'(r), d, 1'b0);
    end
    exp_a = '{32'h00000001, 32'h0, 32'h00000100, 32'h0, 32'h00010000,
              32'h0, 32'h01000000, 32'h0, 32'h0, 32'h0};
    exp_b = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D, 32'h080B0E00,
              32'h0C0F0000, 32'h10000000, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = 4*i + j + 1;
    wr(1'b1, 2'd3, 32'h100F0E0D, 1'b1);
    do_run(1'b1, 1'b1, 1'b1);

    // Run 2: new B with negative entries, A untouched.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) d[8*c +: 8] = 8'(r - c);
      wr(1'b1, 2'(r), d, (r == 3));
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = i - j;
    do_run(1'b0, 1'b0, 1'b0);

    // Run 3: every element -128; feed windows checked byte by byte.
    for (int r = 0; r < 4; r++) wr(1'b0, 2'(r), 32'h80808080, 1'b0);
    for (int r = 0; r < 4; r++) wr(1'b1, 2'(r), 32'h80808080, (r == 3));
    exp_a = '{32'h00000080, 32'h00008080, 32'h00808080, 32'h80808080, 32'h80808000,
              32'h80800000, 32'h80000000, 32'h0, 32'h0, 32'h0};
    exp_b = exp_a;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = 65536;
    do_run(1'b1, 1'b0, 1'b0);

    // Run 4: start reissued the cycle after done; no carry-over from run 3.
    start = 1'b1;
    do_run(1'b1, 1'b0, 1'b0);

    // Run 5: reset in FEED t = 4.
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_a_feed_t4", a_feed, 32'h80808000);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_feeds", a_feed | b_feed, 32'd0);
    chk("midrst_array_rst", {31'd0, array_rst}, 32'd1);
    tick(); tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      tick();
      seen = seen | busy | done | (a_feed != 32'd0) | (b_feed != 32'd0);
    end
    chk("no_activity_after_rst", {31'd0, seen}, 32'd0);

    // Run 6: buffers were cleared by reset, so everything streams zero.
    for (int t = 0; t < 10; t++) begin
      exp_a[t] = '0;
      exp_b[t] = '0;
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = 0;
    start = 1'b1;
    do_run(1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: wr_en  input  1  operand buffer write strobe.
REQ-004 SHALL have port: wr_sel  input  1  0 = matrix A buffer, 1 = matrix B buffer.
REQ-005 SHALL have port: wr_row  input  2  row index being written.
REQ-006 SHALL have port: wr_data  input  32  one row, byte k = element [row][k], signed 8-bit.
REQ-007 SHALL have port: start  input  1  begin one 4x4 matmul.
REQ-008 SHALL have port: a_feed  output  32  byte i drives a_in of array row i, column 0.
REQ-009 SHALL have port: b_feed  output  32  byte j drives b_in of array column j, row 0.
REQ-010 SHALL have port: array_rst  output  1  clears the 4x4 PE array (accumulators and pipeline registers).
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, CLEAR, FEED, DRAIN, DONE; all outputs registered.
REQ-014 SHALL write wr_data into A[wr_row] or B[wr_row] on wr_en only in IDLE; wr_en in any other state is ignored and buffers are unchanged.
REQ-015 SHALL transition IDLE->CLEAR on start; start outside IDLE is ignored (no queueing).
REQ-016 SHALL assert array_rst for exactly the one CLEAR cycle, then enter FEED.
REQ-017 SHALL hold FEED for exactly 10 cycles, t = 0..9, tracked by a 4-bit counter.
REQ-018 SHALL, in FEED cycle t, drive a_feed byte i = A[i][t-i] when 0 <= t-i <= 3, else 0x00.
REQ-019 SHALL, in FEED cycle t, drive b_feed byte j = B[t-j][j] when 0 <= t-j <= 3, else 0x00.
REQ-020 SHALL drive a_feed = b_feed = 0 in every state except FEED.
REQ-021 SHALL spend one DRAIN cycle after t = 9 so that PE(3,3) captures its final product, then enter DONE.
REQ-022 SHALL assert done for the single DONE cycle, then return to IDLE; PE results remain valid until the next CLEAR.
REQ-023 SHALL give a fixed latency: start sampled at edge E0 -> CLEAR in cycle 1, FEED in cycles 2-11, DRAIN in cycle 12, done high in cycle 13.
REQ-024 SHALL accept start in the same cycle that done returns the block to IDLE only from the following cycle (start during DONE is ignored).
REQ-025 SHALL treat the same-cycle wr_en and start in IDLE as: the write is performed, then the run uses the updated buffer.

Reset
REQ-026 SHALL, on rst, immediately force state IDLE, counter 0, a_feed 0, b_feed 0, busy 0, done 0, all A/B buffer bytes 0.
REQ-027 SHALL drive array_rst high while rst is high, so that a reset mid-run also clears the array.
REQ-028 SHALL, after rst deasserts, require a new start before any feed activity.

Verification
REQ-029 SHALL pass: A = identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, start -> done at cycle 13, PE c equals B.
REQ-030 SHALL pass: all A and B elements = -128 -> every PE c = 65536; no sign or width loss.
REQ-031 SHALL pass: trace a_feed/b_feed over FEED -> byte i is zero for t < i and for t > i+3; skew matches REQ-018/019 exactly.
REQ-032 SHALL pass: start and wr_en pulsed in cycle 5 of FEED -> no restart, buffers unchanged, done still at cycle 13.
REQ-033 SHALL pass: rst asserted in FEED t = 4 -> same cycle busy 0, feeds 0, array_rst 1; no done; buffers read back 0 on the next run.
REQ-034 SHALL pass: two back-to-back runs with different B, start reissued the cycle after done -> second result is independent of the first (no residual accumulation).
